// File: rtl/coin_acceptor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared types for the coin acceptor: coin code encoding,
//               FSM state encoding and pattern-decode helpers.
// Contents    : coin_code_t - 00 none, 01 farthing, 10 ha'penny, 11 penny
//               state_t     - IDLE, SETTLE, PRESENT, REJECT, RELEASE
//               is_single() - true when exactly one chute switch is set
//               code_of()   - maps a one-hot chute pattern to coin_code_t
// Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

  localparam int unsigned c_COIN_W = 3;

  typedef enum logic [1:0] {
    CODE_NONE     = 2'b00,
    CODE_FARTHING = 2'b01,
    CODE_HAPENNY  = 2'b10,
    CODE_PENNY    = 2'b11
  } coin_code_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PRESENT = 3'd2,
    ST_REJECT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  function automatic logic is_single(input logic [c_COIN_W-1:0] p);
    return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
  endfunction

  // Chute bit [2] is the penny, [1] the ha'penny, [0] the farthing.
  function automatic coin_code_t code_of(input logic [c_COIN_W-1:0] p);
    coin_code_t w_code;
    case (p)
      3'b001:  w_code = CODE_FARTHING;
      3'b010:  w_code = CODE_HAPENNY;
      3'b100:  w_code = CODE_PENNY;
      default: w_code = CODE_NONE;
    endcase
    return w_code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor_if
// Description : Valid/ready handshake carrying an accepted coin to the
//               downstream vending-machine stage.
// Signals     : coin_valid - accepted coin available (master -> slave)
//               coin_code  - coin code, 00 whenever coin_valid is low
//               coin_ready - downstream consumes the coin (slave -> master)
// Modports    : master - the acceptor; slave - the consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_acceptor_if;
  import coin_pkg::*;

  logic       coin_valid;
  coin_code_t coin_code;
  logic       coin_ready;

  modport master (
    output coin_valid,
    output coin_code,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    input  coin_code,
    output coin_ready
  );

endinterface
`default_nettype wire

// File: rtl/coin_acceptor_sync.sv
`default_nettype none
// ============================================================================
// Module      : coin_sync
// Description : Two-flop synchronizer for the asynchronous chute switches.
// Ports       : clk    - sampling clock
//               rst_n  - asynchronous active-low reset, clears both stages
//               i_d    - raw asynchronous input bus
//               o_q    - synchronized output bus (two clocks of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module coin_sync #(
  parameter int unsigned WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Debounces the three coin-chute switches, hands a single
//               recognised coin downstream over a valid/ready handshake and
//               rejects multi-coin events with a one-cycle pulse.
// Ports       : clk50m      - 50 MHz clock, all state on the rising edge
//               res         - asynchronous active-low reset
//               coin_raw    - raw bouncy switches [2] penny [1] ha'penny
//                             [0] farthing
//               bus         - handshake (coin_valid/coin_code/coin_ready)
//               coin_reject - one-cycle pulse for a rejected multi-coin event
//               busy        - high whenever the FSM is not IDLE
//               accept_cnt  - saturating count of coins handed over
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  wire logic        clk50m,
  input  wire logic        res,
  input  wire logic [2:0]  coin_raw,
  coin_acceptor_if.master  bus,
  output logic             coin_reject,
  output logic             busy,
  output logic [7:0]       accept_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       w_sync;
  state_t           r_state;
  logic [2:0]       r_pattern;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  coin_code_t       r_code;
  logic             r_reject;
  logic             r_busy;
  logic [7:0]       r_accept;

  coin_sync #(
    .WIDTH (c_COIN_W)
  ) u_sync (
    .clk   (clk50m),
    .rst_n (res),
    .i_d   (coin_raw),
    .o_q   (w_sync)
  );

  // Every output is a flop; busy is tracked alongside the state so it never
  // decodes combinationally.
  always_ff @(posedge clk50m or negedge res) begin
    if (!res) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_code    <= CODE_NONE;
      r_reject  <= 1'b0;
      r_busy    <= 1'b0;
      r_accept  <= '0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync != 3'b000) begin
            r_state   <= ST_SETTLE;
            r_pattern <= w_sync;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (w_sync == 3'b000) begin
            // Glitch: the switch let go before it was stable long enough.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_sync != r_pattern) begin
            r_pattern <= w_sync;
            r_cnt     <= '0;
          end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            if (is_single(r_pattern)) begin
              r_state <= ST_PRESENT;
              r_valid <= 1'b1;
              r_code  <= code_of(r_pattern);
            end else begin
              r_state  <= ST_REJECT;
              r_reject <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_PRESENT: begin
          // coin_valid is always high here, so ready alone completes transfer.
          if (bus.coin_ready) begin
            r_state <= ST_RELEASE;
            r_valid <= 1'b0;
            r_code  <= CODE_NONE;
            r_cnt   <= '0;
            if (r_accept != 8'hFF) begin
              r_accept <= r_accept + 8'd1;
            end
          end
        end

        ST_REJECT: begin
          r_state <= ST_RELEASE;
          r_cnt   <= '0;
        end

        ST_RELEASE: begin
          // The chute must read empty for a full debounce window before a
          // new coin can be recognised.
          if (w_sync != 3'b000) begin
            r_cnt <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_code  <= CODE_NONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin_valid = r_valid;
  assign bus.coin_code  = r_code;
  assign coin_reject    = r_reject;
  assign busy           = r_busy;
  assign accept_cnt     = r_accept;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Directed self-checking bench for coin_acceptor with a
//               four-cycle debounce window. Inputs change 1 time unit after
//               each rising edge and outputs are read at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;
  import coin_pkg::*;

  logic       clk;
  logic       res;
  logic [2:0] coin_raw;
  logic       coin_reject;
  logic       busy;
  logic [7:0] accept_cnt;

  int checks;
  int failures;

  coin_acceptor_if bus_if ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk50m      (clk),
    .res         (res),
    .coin_raw    (coin_raw),
    .bus         (bus_if),
    .coin_reject (coin_reject),
    .busy        (busy),
    .accept_cnt  (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic stable;
    logic seen;

    checks    = 0;
    failures  = 0;
    res       = 1'b0;
    coin_raw  = 3'b000;
    bus_if.coin_ready = 1'b0;

    // Reset state
    tick(3);
    chk("rst_valid",  32'(bus_if.coin_valid), 32'd0);
    chk("rst_code",   32'(bus_if.coin_code),  32'd0);
    chk("rst_reject", 32'(coin_reject),       32'd0);
    chk("rst_busy",   32'(busy),              32'd0);
    chk("rst_cnt",    32'(accept_cnt),        32'd0);
    res = 1'b1;
    tick(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Penny held with ready high: valid after edge 7 for one cycle
    bus_if.coin_ready = 1'b1;
    coin_raw = 3'b100;
    tick(2);
    chk("p_busy_e2", 32'(busy), 32'd0);
    tick(1);
    chk("p_busy_e3", 32'(busy), 32'd1);
    tick(3);
    chk("p_valid_e6", 32'(bus_if.coin_valid), 32'd0);
    tick(1);
    chk("p_valid_e7", 32'(bus_if.coin_valid), 32'd1);
    chk("p_code_e7",  32'(bus_if.coin_code),  32'd3);
    chk("p_cnt_e7",   32'(accept_cnt),        32'd0);
    tick(1);
    chk("p_valid_e8", 32'(bus_if.coin_valid), 32'd0);
    chk("p_code_e8",  32'(bus_if.coin_code),  32'd0);
    chk("p_cnt_e8",   32'(accept_cnt),        32'd1);
    coin_raw = 3'b000;
    tick(5);
    chk("p_rel_busy5", 32'(busy), 32'd1);
    tick(1);
    chk("p_rel_busy6", 32'(busy), 32'd0);

    // Ha'penny with ready held off; raw changes during PRESENT are ignored
    bus_if.coin_ready = 1'b0;
    coin_raw = 3'b010;
    tick(7);
    chk("h_valid", 32'(bus_if.coin_valid), 32'd1);
    chk("h_code",  32'(bus_if.coin_code),  32'd2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) coin_raw = 3'b110;
      tick(1);
      if (bus_if.coin_valid !== 1'b1 || bus_if.coin_code !== CODE_HAPENNY) stable = 1'b0;
    end
    chk("h_hold_stable", 32'(stable), 32'd1);
    bus_if.coin_ready = 1'b1;
    tick(1);
    chk("h_valid_drop", 32'(bus_if.coin_valid), 32'd0);
    chk("h_code_drop",  32'(bus_if.coin_code),  32'd0);
    chk("h_cnt",        32'(accept_cnt),        32'd2);
    chk("h_busy_rel",   32'(busy),              32'd1);
    coin_raw = 3'b000;
    tick(5);
    chk("h_rel_busy5", 32'(busy), 32'd1);
    tick(1);
    chk("h_rel_busy6", 32'(busy), 32'd0);
    // Ready while nothing is presented must not count a coin
    tick(3);
    chk("idle_ready_cnt",   32'(accept_cnt),        32'd2);
    chk("idle_ready_valid", 32'(bus_if.coin_valid), 32'd0);

    // Bouncy farthing: 2 high, 1 low repeatedly never qualifies
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      coin_raw = 3'b001;
      tick(1); seen = seen | bus_if.coin_valid | coin_reject;
      tick(1); seen = seen | bus_if.coin_valid | coin_reject;
      coin_raw = 3'b000;
      tick(1); seen = seen | bus_if.coin_valid | coin_reject;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1); seen = seen | bus_if.coin_valid | coin_reject;
    end
    chk("bounce_no_output", 32'(seen), 32'd0);
    chk("bounce_idle",      32'(busy), 32'd0);
    coin_raw = 3'b001;
    tick(7);
    chk("f_valid", 32'(bus_if.coin_valid), 32'd1);
    chk("f_code",  32'(bus_if.coin_code),  32'd1);
    tick(1);
    chk("f_cnt", 32'(accept_cnt), 32'd3);
    coin_raw = 3'b000;
    tick(6);
    chk("f_idle", 32'(busy), 32'd0);

    // Two coins at once: one-cycle reject pulse, nothing presented
    coin_raw = 3'b110;
    tick(6);
    chk("r_reject_e6", 32'(coin_reject), 32'd0);
    tick(1);
    chk("r_reject_e7", 32'(coin_reject),       32'd1);
    chk("r_valid_e7",  32'(bus_if.coin_valid), 32'd0);
    tick(1);
    chk("r_reject_e8", 32'(coin_reject),       32'd0);
    chk("r_valid_e8",  32'(bus_if.coin_valid), 32'd0);
    chk("r_cnt",       32'(accept_cnt),        32'd3);
    coin_raw = 3'b000;
    tick(6);
    chk("r_idle", 32'(busy), 32'd0);

    // Reset while a coin is presented clears everything at once
    bus_if.coin_ready = 1'b0;
    coin_raw = 3'b100;
    tick(7);
    chk("m_valid_pre", 32'(bus_if.coin_valid), 32'd1);
    #2;
    res = 1'b0;
    coin_raw = 3'b000;
    #1;
    chk("m_valid", 32'(bus_if.coin_valid), 32'd0);
    chk("m_code",  32'(bus_if.coin_code),  32'd0);
    chk("m_busy",  32'(busy),              32'd0);
    chk("m_cnt",   32'(accept_cnt),        32'd0);
    tick(2);
    res = 1'b1;
    tick(3);
    chk("m_after_busy",  32'(busy),              32'd0);
    chk("m_after_valid", 32'(bus_if.coin_valid), 32'd0);

    // Coin held through reset is a fresh insertion afterwards
    res = 1'b0;
    coin_raw = 3'b001;
    tick(2);
    res = 1'b1;
    tick(6);
    chk("held_valid_e6", 32'(bus_if.coin_valid), 32'd0);
    tick(1);
    chk("held_valid_e7", 32'(bus_if.coin_valid), 32'd1);
    chk("held_code_e7",  32'(bus_if.coin_code),  32'd1);
    bus_if.coin_ready = 1'b1;
    tick(1);
    chk("held_cnt", 32'(accept_cnt), 32'd1);
    coin_raw = 3'b000;
    tick(6);

    // Saturation: 254 more handshakes reach 255, one more stays at 255
    for (int i = 0; i < 254; i++) begin
      coin_raw = 3'b001;
      tick(8);
      coin_raw = 3'b000;
      tick(6);
    end
    chk("sat_255", 32'(accept_cnt), 32'd255);
    coin_raw = 3'b001;
    tick(7);
    chk("sat_valid", 32'(bus_if.coin_valid), 32'd1);
    tick(1);
    chk("sat_valid_drop", 32'(bus_if.coin_valid), 32'd0);
    chk("sat_hold",       32'(accept_cnt),        32'd255);
    coin_raw = 3'b000;
    tick(6);
    chk("sat_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
